ram_burst_master: RTL and testbench
===================================

Name: ram_burst_master

Overview:
- Initiator for the single-port synchronous RAM interface: RDEN, WREN, ADDR, write data, and read data with 1-cycle read latency.
- Accepts burst commands on a valid/ready port.
- Write bursts: streams write data from a valid/ready stream into the RAM.
- Read bursts: returns RAM read data on a valid/ready stream, with full backpressure.
- Sits between a DMA/stream client and the RAM macro.

Parameters:
- DATA_W, 16, RAM word width.
- ADDR_W, 12, RAM address width.
- RAM_SIZE, 3072, number of words; addresses wrap modulo RAM_SIZE.
- LEN_W, 8, burst length field width; CMD_LEN encodes beats-1, so 1..256 beats.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  reset, asynchronous, active-low.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  command accept; high only in IDLE.
- CMD_WRITE  in  1  1=write burst, 0=read burst.
- CMD_ADDR  in  ADDR_W  start word address.
- CMD_LEN  in  LEN_W  beats minus one.
- WR_VALID  in  1  write data valid.
- WR_READY  out  1  write data ready; high only in WRITE.
- WR_DATA  in  DATA_W  write beat.
- RD_VALID  out  1  read data valid (skid FIFO non-empty).
- RD_READY  in  1  read data ready.
- RD_DATA  out  DATA_W  read beat (FIFO head).
- RD_LAST  out  1  marks the final beat of a read burst.
- RAM_RDEN  out  1  RAM read enable.
- RAM_WREN  out  1  RAM write enable.
- RAM_ADDR  out  ADDR_W  RAM address.
- RAM_WDATA  out  DATA_W  RAM write data (= WR_DATA).
- RAM_RDATA  in  DATA_W  RAM read data, valid the cycle after RAM_RDEN.
- BUSY  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset (async assert, sync release):
  - State=IDLE, FIFO empty, inflight=0, address/beat counters 0.
  - Outputs: CMD_READY=1, WR_READY=0, RD_VALID=0, RD_LAST=0, RAM_RDEN=0, RAM_WREN=0, BUSY=0.
  - Reset mid-burst aborts the burst; no further RAM access; FIFO contents discarded.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - On CMD_VALID&CMD_READY: latch addr and remaining=CMD_LEN.
  - Go to WRITE if CMD_WRITE, else READ.
- WRITE:
  - WR_READY=1; RAM_WREN=WR_VALID; RAM_ADDR=cur addr, combinational.
  - The write happens at the same edge as the WR handshake.
  - Per beat: addr advances, with RAM_SIZE-1 -> 0.
  - Last beat (remaining==0) -> IDLE.
  - WR_VALID low inserts bubbles; no timeout.
- READ:
  - RAM_RDEN=1 iff count + inflight - (RD_VALID&RD_READY) < 2; count = FIFO occupancy (0..2), inflight = RDEN issued last cycle.
  - RAM_RDATA is pushed into the FIFO on the edge after RDEN, tagged with a last flag.
  - Address advances and wraps per issue.
  - After the last issue -> DRAIN.
  - Sustains 1 beat/cycle when RD_READY is held high.
- DRAIN: -> IDLE when inflight=0 and FIFO empty, so CMD_READY never rises while read data is outstanding.
- Latency:
  - Write: 0 cycles from handshake to RAM write.
  - Read: command accept edge E; RDEN high in cycle E+1; RD_VALID high after edge E+2.
- Simultaneous FIFO push and pop: allowed; count unchanged.
- RAM_WREN and RAM_RDEN are never both high. RAM_ADDR = 0 when idle.

Optional Feature:
- Macro RAM_BURST_RANGE_CHECK_EN.
- Defined:
  - A command with CMD_ADDR >= RAM_SIZE is accepted but not executed: no RAM access, state stays IDLE.
  - Extra output ERR_ADDR pulses high for exactly 1 cycle after the accept edge.
  - For such a command, a write burst's data is not consumed.
- Undefined:
  - No ERR_ADDR port.
  - Out-of-range start addresses are used as-is; wrap logic only triggers at RAM_SIZE-1.

Decomposition:
- Package ram_master_pkg:
  - state enum (IDLE, WRITE, READ, DRAIN).
  - FIFO entry struct {last, data}.
  - Function next_addr(addr, RAM_SIZE) with wrap.
- Sub-module ram_rd_skid: 2-entry FIFO with push/pop/count, registered head output.

Test Plan:
- Write burst addr=10, len=3 (4 beats 0xA000..0xA003), WR_VALID held high -> RAM_WREN high for 4 consecutive cycles at addrs 10..13, then CMD_READY=1.
- Read burst addr=10, len=3, RD_READY=1 -> RD_VALID first asserted 2 cycles after accept; 4 consecutive beats 0xA000..0xA003; RD_LAST only on 0xA003.
- Read of 6 beats, RD_READY toggling 1,0,0,1,... -> no beat lost or duplicated; FIFO count never >2; RDEN stalls while FIFO full.
- Write then read at addr=3070, len=3 -> accesses 3070, 3071, 0, 1; data round-trips intact.
- RST_N asserted mid read burst (after 2 beats issued) -> RD_VALID=0 and RAM_RDEN=0 immediately; CMD_READY=1 after release.
- With RAM_BURST_RANGE_CHECK_EN: command addr=3072 -> ERR_ADDR 1-cycle pulse, no RAM_RDEN/RAM_WREN, BUSY stays 0.

Source files
------------

// File: rtl/ram_master_pkg.sv
// ---------------------------------------------------------------------------
// ram_master_pkg: shared types and address helper for the RAM burst master.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram_master_pkg;

  localparam int RAM_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic                  last;
    logic [RAM_DATA_W-1:0] data;
  } rd_entry_t;

  // Wraps only at ram_size-1; other values simply increment.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [31:0] ram_size);
    if (addr == ram_size - 32'd1) return 32'd0;
    return addr + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_rd_skid.sv
// ---------------------------------------------------------------------------
// ram_rd_skid: 2-entry read-return FIFO; head entry is a register.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_rd_skid
  import ram_master_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  rd_entry_t push_entry_i,
  input  logic      pop_i,
  output rd_entry_t head_o,
  output logic [1:0] count_o
);

  rd_entry_t  head_q, head_d;
  rd_entry_t  tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       w_pop;

  assign w_pop = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_i, w_pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_entry_i;
        else                 tail_d = push_entry_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_entry_i;
        end else begin
          head_d = tail_q;
          tail_d = push_entry_i;
        end
      end
      default: ;
    endcase
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ram_burst_master.sv
// ---------------------------------------------------------------------------
// ram_burst_master: valid/ready burst initiator for a 1-cycle-latency RAM.
// Optional feature macro: RAM_BURST_RANGE_CHECK_EN (adds err_addr_o).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_burst_master
  import ram_master_pkg::*;
#(
  parameter int DATA_W   = RAM_DATA_W,
  parameter int ADDR_W   = 12,
  parameter int RAM_SIZE = 3072,
  parameter int LEN_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  output logic              ram_rden_o,
  output logic              ram_wren_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o
`ifdef RAM_BURST_RANGE_CHECK_EN
  ,
  output logic              err_addr_o
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [ADDR_W-1:0] w_addr_next;
  logic              w_pop;
  logic              w_room;
  logic [1:0]        w_count;
  rd_entry_t         w_push_entry;
  rd_entry_t         w_head;

`ifdef RAM_BURST_RANGE_CHECK_EN
  logic err_q, err_d;
  logic w_cmd_oob;
  assign w_cmd_oob  = 32'(cmd_addr_i) >= 32'(RAM_SIZE);
  assign err_addr_o = err_q;
`endif

  assign w_addr_next = ADDR_W'(next_addr(32'(addr_q), 32'(RAM_SIZE)));
  assign w_pop       = rd_valid_o && rd_ready_i;
  // A read may issue only if its data is guaranteed a FIFO slot when it returns.
  assign w_room      = ({1'b0, w_count} + {2'b00, inflight_q} - {2'b00, w_pop}) < 3'd2;

  assign inflight_d      = ram_rden_o;
  assign inflight_last_d = ram_rden_o && (remain_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
`ifdef RAM_BURST_RANGE_CHECK_EN
      err_q           <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
`ifdef RAM_BURST_RANGE_CHECK_EN
      err_q           <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
`ifdef RAM_BURST_RANGE_CHECK_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          addr_d   = cmd_addr_i;
          remain_d = cmd_len_i;
          state_d  = cmd_write_i ? ST_WRITE : ST_READ;
`ifdef RAM_BURST_RANGE_CHECK_EN
          if (w_cmd_oob) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
`endif
        end
      end
      ST_WRITE: begin
        if (wr_valid_i) begin
          addr_d   = w_addr_next;
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == '0) state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (ram_rden_o) begin
          addr_d   = w_addr_next;
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == '0) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (w_count == 2'd0)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    ram_wren_o  = 1'b0;
    ram_rden_o  = 1'b0;
    ram_addr_o  = '0;
    case (state_q)
      ST_IDLE:  cmd_ready_o = 1'b1;
      ST_WRITE: begin
        wr_ready_o = 1'b1;
        ram_wren_o = wr_valid_i;
        ram_addr_o = addr_q;
      end
      ST_READ: begin
        ram_rden_o = w_room;
        ram_addr_o = addr_q;
      end
      default: ;
    endcase
  end

  assign w_push_entry.last = inflight_last_q;
  assign w_push_entry.data = ram_rdata_i;

  ram_rd_skid u_skid (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (inflight_q),
    .push_entry_i (w_push_entry),
    .pop_i        (w_pop),
    .head_o       (w_head),
    .count_o      (w_count)
  );

  assign rd_valid_o  = (w_count != 2'd0);
  assign rd_data_o   = w_head.data;
  assign rd_last_o   = rd_valid_o && w_head.last;
  assign ram_wdata_o = wr_data_i;
  assign busy_o      = (state_q != ST_IDLE) || rd_valid_o;

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_master.sv
// ---------------------------------------------------------------------------
// tb_ram_burst_master: directed self-checking bench with a behavioural RAM.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_burst_master;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 12;
  localparam int RAM_SIZE = 3072;
  localparam int LEN_W    = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready, rd_last;
  logic [DATA_W-1:0] rd_data;
  logic              ram_rden, ram_wren;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              busy;
`ifdef RAM_BURST_RANGE_CHECK_EN
  logic              err_addr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] mem [0:4095];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    if (ram_rden) ram_rdata <= mem[ram_addr];
  end

  ram_burst_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_SIZE(RAM_SIZE), .LEN_W(LEN_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_data_i   (wr_data),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .rd_data_o   (rd_data),
    .rd_last_o   (rd_last),
    .ram_rden_o  (ram_rden),
    .ram_wren_o  (ram_wren),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .busy_o      (busy)
`ifdef RAM_BURST_RANGE_CHECK_EN
    ,
    .err_addr_o  (err_addr)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    if ({cmd_ready, wr_ready, rd_valid, rd_last, ram_rden, ram_wren, busy} !== 7'b1000000) begin
      n_err++; $display("FAIL reset_in got %b want 1000000",
                        {cmd_ready, wr_ready, rd_valid, rd_last, ram_rden, ram_wren, busy});
    end
    n_cmp++;
    rst_n = 1'b1;
    @(negedge clk); #1;
    if ({cmd_ready, wr_ready, rd_valid, rd_last, ram_rden, ram_wren, busy} !== 7'b1000000) begin
      n_err++; $display("FAIL reset_out got %b want 1000000",
                        {cmd_ready, wr_ready, rd_valid, rd_last, ram_rden, ram_wren, busy});
    end
    n_cmp++;
    if (ram_addr !== 12'd0) begin
      n_err++; $display("FAIL reset_addr got %0d want 0", ram_addr);
    end
    n_cmp++;
  endtask

  task automatic test_write(input int addr, input int len, input logic [15:0] base, input bit bubble);
    int beat = 0;
    int cyc  = 0;
    int exp_addr;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr[11:0]; cmd_len = len[7:0];
    wr_valid = 1'b0; wr_data = '0;
    #1;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL wr_cmd_ready got %b want 1", cmd_ready);
    end
    n_cmp++;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (beat <= len && cyc < 40) begin
      cyc++;
      wr_valid = !(bubble && cyc == 2);
      wr_data  = base + 16'(beat);
      #1;
      exp_addr = (addr + beat) % RAM_SIZE;
      if ({wr_ready, ram_wren, ram_rden} !== {1'b1, wr_valid, 1'b0}) begin
        n_err++; $display("FAIL wr_ctrl beat %0d got %b want %b", beat,
                          {wr_ready, ram_wren, ram_rden}, {1'b1, wr_valid, 1'b0});
      end
      n_cmp++;
      if (wr_valid) begin
        if (ram_addr !== exp_addr[11:0] || ram_wdata !== wr_data) begin
          n_err++; $display("FAIL wr_beat %0d got addr %0d data %h want addr %0d data %h",
                            beat, ram_addr, ram_wdata, exp_addr, wr_data);
        end
        n_cmp++;
        beat++;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    if (beat != len + 1) begin
      n_err++; $display("FAIL wr_timeout got %0d beats want %0d", beat, len + 1);
    end
    n_cmp++;
    if ({cmd_ready, ram_wren, wr_ready, busy} !== 4'b1000) begin
      n_err++; $display("FAIL wr_end got %b want 1000", {cmd_ready, ram_wren, wr_ready, busy});
    end
    n_cmp++;
  endtask

  task automatic test_read(input int addr, input int len, input logic [15:0] base,
                           input bit throttle, input bit check_lat);
    int cyc = 0, got = 0, issued = 0, first = -1, wait_cyc = 0, exp_addr;
    bit overflow = 1'b0, both = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr[11:0]; cmd_len = len[7:0];
    rd_ready = 1'b1;
    #1;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL rd_cmd_ready got %b want 1", cmd_ready);
    end
    n_cmp++;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (got <= len && cyc < 100) begin
      cyc++;
      rd_ready = throttle ? ((cyc % 3) == 1) : 1'b1;
      #1;
      if (ram_rden) begin
        exp_addr = (addr + issued) % RAM_SIZE;
        if (ram_addr !== exp_addr[11:0]) begin
          n_err++; $display("FAIL rd_issue %0d got addr %0d want %0d", issued, ram_addr, exp_addr);
        end
        n_cmp++;
        issued++;
      end
      if (ram_rden && ram_wren) both = 1'b1;
      if (rd_valid && first < 0) first = cyc;
      if (!rd_valid && rd_last !== 1'b0) begin
        n_err++; $display("FAIL rd_last_idle cyc %0d got %b want 0", cyc, rd_last);
      end
      if (!rd_valid) n_cmp++;
      if (rd_valid && rd_ready) begin
        if (rd_data !== base + 16'(got) || rd_last !== (got == len)) begin
          n_err++; $display("FAIL rd_beat %0d got data %h last %b want data %h last %b",
                            got, rd_data, rd_last, base + 16'(got), (got == len));
        end
        n_cmp++;
        got++;
      end
      if (issued - got > 2) overflow = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b1;
    #1;
    if (got != len + 1 || issued != len + 1) begin
      n_err++; $display("FAIL rd_count got %0d beats %0d issues want %0d", got, issued, len + 1);
    end
    n_cmp++;
    if ({overflow, both} !== 2'b00) begin
      n_err++; $display("FAIL rd_outstanding got overflow %b rden_wren %b want 0 0", overflow, both);
    end
    n_cmp++;
    if (check_lat) begin
      if (first != 3) begin
        n_err++; $display("FAIL rd_latency got cycle %0d want 3", first);
      end
      n_cmp++;
    end
    while (cmd_ready !== 1'b1 && wait_cyc < 10) begin
      @(negedge clk); #1;
      wait_cyc++;
    end
    if ({cmd_ready, busy, rd_valid, ram_rden} !== 4'b1000) begin
      n_err++; $display("FAIL rd_end got %b want 1000", {cmd_ready, busy, rd_valid, ram_rden});
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'd10; cmd_len = 8'd7; rd_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    if (ram_rden !== 1'b1) begin
      n_err++; $display("FAIL mid_issue1 got %b want 1", ram_rden);
    end
    n_cmp++;
    @(negedge clk); #1;
    if (ram_rden !== 1'b1) begin
      n_err++; $display("FAIL mid_issue2 got %b want 1", ram_rden);
    end
    n_cmp++;
    @(negedge clk); #1;
    if ({rd_valid, ram_rden, busy} !== 3'b101) begin
      n_err++; $display("FAIL mid_full got %b want 101", {rd_valid, ram_rden, busy});
    end
    n_cmp++;
    rst_n = 1'b0;
    #1;
    if ({rd_valid, ram_rden, ram_wren, busy} !== 4'b0000) begin
      n_err++; $display("FAIL mid_rst got %b want 0000", {rd_valid, ram_rden, ram_wren, busy});
    end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      if ({cmd_ready, rd_valid, ram_rden, busy} !== 4'b1000) begin
        n_err++; $display("FAIL mid_release got %b want 1000", {cmd_ready, rd_valid, ram_rden, busy});
      end
      n_cmp++;
    end
  endtask

`ifdef RAM_BURST_RANGE_CHECK_EN
  task automatic test_range_check(input bit is_write);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = is_write; cmd_addr = 12'd3072; cmd_len = 8'd3;
    wr_valid = is_write; wr_data = 16'hDEAD;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    if ({err_addr, ram_rden, ram_wren, wr_ready, busy, cmd_ready} !== 6'b100001) begin
      n_err++; $display("FAIL oob_pulse got %b want 100001",
                        {err_addr, ram_rden, ram_wren, wr_ready, busy, cmd_ready});
    end
    n_cmp++;
    @(negedge clk); #1;
    if ({err_addr, ram_rden, ram_wren, busy} !== 4'b0000) begin
      n_err++; $display("FAIL oob_after got %b want 0000", {err_addr, ram_rden, ram_wren, busy});
    end
    n_cmp++;
    wr_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_write(10, 3, 16'hA000, 1'b0);
    test_read(10, 3, 16'hA000, 1'b0, 1'b1);
    test_write(20, 5, 16'hB000, 1'b1);
    test_read(20, 5, 16'hB000, 1'b1, 1'b1);
    test_write(3070, 3, 16'hC000, 1'b0);
    test_read(3070, 3, 16'hC000, 1'b0, 1'b1);
    test_reset_mid_read();
    test_read(20, 5, 16'hB000, 1'b0, 1'b1);
`ifdef RAM_BURST_RANGE_CHECK_EN
    test_range_check(1'b0);
    test_range_check(1'b1);
    test_read(10, 3, 16'hA000, 1'b0, 1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
